// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage forwarding pipeline: load-use stalls,
// EX redirects, multi-cycle MUL occupancy and EX forwarding selects. Optional PERF_CNT_EN.
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_W   = 5,
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] ex_rs,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_memRead,
  input  logic             ex_is_mul,
  input  logic             ex_redirect,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_wen,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_wen,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mul_busy,
  output logic             mul_done
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
`endif
);

  localparam int unsigned MCW = $clog2(MUL_LAT) + 1;
  localparam logic [MCW-1:0] LAST = MCW'(MUL_LAT - 1);
  localparam bit MUL_EN = (MUL_LAT > 1);

  typedef enum logic {RUN, MUL_WAIT} state_t;

  state_t         state, state_nx;
  logic [MCW-1:0] cnt, cnt_nx;
  logic           mul_stall;
  logic           load_use;
  logic           redirect_cyc;

  assign load_use = ex_memRead && (ex_rd != '0) &&
                    ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    mul_stall    = 1'b0;
    mul_done     = 1'b0;
    redirect_cyc = 1'b0;
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_flush  = 1'b0;

    case (state)
      RUN: begin
        if (ex_is_mul) begin
          if (MUL_EN) begin
            mul_stall = 1'b1;
            state_nx  = MUL_WAIT;
            cnt_nx    = MCW'(1);
          end else begin
            mul_done = 1'b1;
          end
        end
      end
      MUL_WAIT: begin
        if (cnt < LAST) begin
          mul_stall = 1'b1;
          cnt_nx    = cnt + MCW'(1);
        end else begin
          mul_done = 1'b1;
          state_nx = RUN;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = RUN;
        cnt_nx   = '0;
      end
    endcase

    // Priority chain: reset overrides the FSM-derived stall, which overrides redirect/load-use.
    if (rst) begin
      mul_stall   = 1'b0;
      mul_done    = 1'b0;
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (mul_stall) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_flush = 1'b1;
    end else if (ex_redirect) begin
      redirect_cyc = 1'b1;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
    end else if (load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  assign mul_busy = mul_stall;

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (!rst) begin
      if (mem_wen && (mem_rd != '0) && (mem_rd == ex_rs))
        fwd_a = 2'b10;
      else if (wb_wen && (wb_rd != '0) && (wb_rd == ex_rs))
        fwd_a = 2'b01;
      if (mem_wen && (mem_rd != '0) && (mem_rd == ex_rt))
        fwd_b = 2'b10;
      else if (wb_wen && (wb_rd != '0) && (wb_rd == ex_rt))
        fwd_b = 2'b01;
    end
  end

`ifdef PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!pc_en && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (redirect_cyc && (flush_count != '1))
        flush_count <= flush_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (MUL_LAT=4).
module tb_pipeline_hazard_ctrl;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned MUL_LAT = 4;
  localparam int unsigned CNT_W   = 16;

  // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_flush, mul_busy, mul_done}
  localparam logic [7:0] C_RESET = 8'b0010_1100;
  localparam logic [7:0] C_NORM  = 8'b1101_0000;
  localparam logic [7:0] C_MULS  = 8'b0000_0110;
  localparam logic [7:0] C_DONE  = 8'b1101_0001;
  localparam logic [7:0] C_LU    = 8'b0001_1000;
  localparam logic [7:0] C_RED   = 8'b1111_1000;

  logic             clk = 1'b0;
  logic             rst;
  logic [REG_W-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic             id_uses_rt, ex_memRead, ex_is_mul, ex_redirect, mem_wen, wb_wen;
  logic             pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_flush;
  logic [1:0]       fwd_a, fwd_b;
  logic             mul_busy, mul_done;
`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles, flush_count;
`endif

  int checks = 0;
  int errors = 0;

  pipeline_hazard_ctrl #(.REG_W(REG_W), .MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_memRead(ex_memRead), .ex_is_mul(ex_is_mul), .ex_redirect(ex_redirect),
    .mem_rd(mem_rd), .mem_wen(mem_wen), .wb_rd(wb_rd), .wb_wen(wb_wen),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mul_busy(mul_busy), .mul_done(mul_done)
`ifdef PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  // Redirect during a MUL stall is illegal; the stimulus must never produce it.
  always @(negedge clk) begin
    if (rst === 1'b0 && mul_busy === 1'b1) begin
      checks++;
      assert (ex_redirect === 1'b0)
        else begin errors++; $error("FAIL redirect_in_mul: observed ex_redirect=%b expected 0", ex_redirect); end
    end
  end

  task automatic chk_ctl(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    obs = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_flush, mul_busy, mul_done};
    checks++;
    assert (obs === exp)
      else begin errors++; $error("FAIL %s: observed %b expected %b", tag, obs, exp); end
  endtask

  task automatic chk_fwd(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp)
      else begin errors++; $error("FAIL %s: observed %b expected %b", tag, obs, exp); end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;
    ex_rs = '0; ex_rt = '0; ex_rd = '0; ex_memRead = 1'b0;
    ex_is_mul = 1'b1; ex_redirect = 1'b0;
    mem_rd = 5'd7; mem_wen = 1'b1; wb_rd = '0; wb_wen = 1'b0;
    ex_rs = 5'd7;

    // 1: reset with MUL pending, forwarding held at regfile
    #1;
    chk_ctl("rst_c0", C_RESET);
    chk_fwd("rst_fwd_a", fwd_a, 2'b00);
    tick();
    chk_ctl("rst_c1", C_RESET);
    tick();
    rst = 1'b0; ex_is_mul = 1'b0; mem_rd = '0; mem_wen = 1'b0; ex_rs = '0;
    #1;
    chk_ctl("post_rst_c0", C_NORM);
    tick();
    chk_ctl("post_rst_c1", C_NORM);

    // 2: MUL held, then back-to-back MUL
    ex_is_mul = 1'b1;
    #1; chk_ctl("mul1_c1", C_MULS); tick();
    chk_ctl("mul1_c2", C_MULS); tick();
    chk_ctl("mul1_c3", C_MULS); tick();
    chk_ctl("mul1_c4_done", C_DONE); tick();
    chk_ctl("mul2_c1", C_MULS); tick();
    chk_ctl("mul2_c2", C_MULS); tick();
    chk_ctl("mul2_c3", C_MULS); tick();
    chk_ctl("mul2_c4_done", C_DONE); tick();
    ex_is_mul = 1'b0;
    #1; chk_ctl("mul_after", C_NORM); tick();

    // 3: load-use via rs, then rt, then r0 destination
    ex_memRead = 1'b1; ex_rd = 5'd5; id_rs = 5'd5;
    #1; chk_ctl("lu_rs", C_LU); tick();
    ex_memRead = 1'b0;
    #1; chk_ctl("lu_cleared", C_NORM); tick();
    ex_memRead = 1'b1; id_rs = 5'd3; id_rt = 5'd5; id_uses_rt = 1'b1;
    #1; chk_ctl("lu_rt", C_LU); tick();
    id_uses_rt = 1'b0;
    #1; chk_ctl("lu_rt_unused", C_NORM); tick();
    ex_rd = 5'd0; id_rs = 5'd0;
    #1; chk_ctl("lu_r0", C_NORM); tick();

    // 4: redirect beats load-use; MUL beats load-use
    ex_rd = 5'd5; id_rs = 5'd5; ex_redirect = 1'b1;
    #1; chk_ctl("redir_lu", C_RED); tick();
    ex_memRead = 1'b0;
    #1; chk_ctl("redir_only", C_RED); tick();
    ex_redirect = 1'b0; ex_memRead = 1'b1; ex_is_mul = 1'b1;
    #1; chk_ctl("mul_over_lu", C_MULS); tick();
    ex_memRead = 1'b0;
    #1; chk_ctl("mul3_c2", C_MULS); tick();
    chk_ctl("mul3_c3", C_MULS); tick();
    ex_is_mul = 1'b0;
    #1; chk_ctl("mul3_done", C_DONE); tick();

    // 5: forwarding priority and r0
    ex_rs = 5'd7; mem_rd = 5'd7; wb_rd = 5'd7; mem_wen = 1'b1; wb_wen = 1'b1;
    #1; chk_fwd("fwd_a_mem", fwd_a, 2'b10);
    mem_wen = 1'b0;
    #1; chk_fwd("fwd_a_wb", fwd_a, 2'b01);
    wb_wen = 1'b0;
    #1; chk_fwd("fwd_a_none", fwd_a, 2'b00);
    ex_rt = 5'd0; wb_rd = 5'd0; mem_rd = 5'd0; wb_wen = 1'b1; mem_wen = 1'b1;
    #1; chk_fwd("fwd_b_r0", fwd_b, 2'b00);
    ex_rt = 5'd9; mem_rd = 5'd9; wb_rd = 5'd9;
    #1; chk_fwd("fwd_b_mem", fwd_b, 2'b10);
    chk_fwd("fwd_a_nomatch", fwd_a, 2'b00);
    mem_wen = 1'b0;
    #1; chk_fwd("fwd_b_wb", fwd_b, 2'b01);
    wb_wen = 1'b0; tick();

    // 6: reset at cnt=2 abandons the MUL wait
    ex_is_mul = 1'b1;
    #1; chk_ctl("mul4_c1", C_MULS); tick();
    chk_ctl("mul4_c2", C_MULS); tick();
    rst = 1'b1;
    #1; chk_ctl("mul4_rst", C_RESET); tick();
    rst = 1'b0; ex_is_mul = 1'b0;
    #1; chk_ctl("mul4_post_c0", C_NORM); tick();
    chk_ctl("mul4_post_c1", C_NORM); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
